uart: RTL and testbench
=======================

Name: uart

Overview:
- 8N1 UART receiver with echo transmitter.
- Samples asynchronous serial input `rxd` and presents the last correctly framed byte on `echo`.
- Retransmits each received byte on `txd` at the same baud rate.
- Sits at the board serial pin pair as a loopback/console front end.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per serial bit (50 MHz / 115200); must be >= 4.
- SYNC_STAGES, 2: flip-flop stages synchronising `rxd`; must be >= 2.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- rxd  input  1  serial receive line, idle high, asynchronous to clk.
- echo  output  8  last byte received with a valid stop bit.
- rx_valid  output  1  one-cycle pulse when `echo` is updated.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- txd  output  1  serial transmit line, idle high.
- tx_busy  output  1  high while the transmitter is sending a frame.

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - echo=8'h00, rx_valid=0, frame_err=0, txd=1, tx_busy=0.
  - Synchroniser stages preset to 1; both FSMs to IDLE; all counters 0.
- Synchroniser: `rxd` passes through SYNC_STAGES flops; only the synchronised signal `rxs` is used.
- HALF = CLKS_PER_BIT/2 (217 at default).
- Receiver FSM, states IDLE, START, DATA, STOP, BREAK:
  - IDLE: when rxs=0, go to START and clear the counter.
  - START: count HALF cycles, then sample rxs.
    - rxs=1 (glitch): back to IDLE, nothing reported.
    - rxs=0: go to DATA with bit index 0.
  - DATA: sample every CLKS_PER_BIT cycles.
    - Shift the sample in LSB first (bit 0 first).
    - After the 8th sample, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rxs=1: on that same clock edge, load echo with the shift register, pulse rx_valid for one cycle, go to IDLE.
    - rxs=0: echo unchanged, pulse frame_err for one cycle, go to BREAK.
  - BREAK: stay until rxs=1, then go to IDLE.
- Latency: echo changes 2 + HALF + 9·CLKS_PER_BIT cycles (4125 at default, ±1) after the falling edge of `rxd` at the pin.
- echo holds its value indefinitely between frames.
- Transmitter FSM, states IDLE, START, DATA, STOP:
  - Each state lasts CLKS_PER_BIT cycles.
  - On rx_valid while tx IDLE: latch echo, raise tx_busy, send start (0), 8 data bits LSB first, stop (1).
  - tx_busy drops when the stop bit completes.
  - rx_valid while tx_busy: the byte is not transmitted (dropped); echo is still updated.
- Simultaneous events: rx_valid in the same cycle the tx finishes its stop bit is dropped; tx must be IDLE in the cycle rx_valid is high.
- Reset mid-frame: both FSMs abort immediately; txd returns high; no pulses generated.
- A rxd low held from reset release starts a frame after synchronisation (treated as a start bit).

Decomposition:
- Shared package uart_pkg:
  - rx_state_t (IDLE, START, DATA, STOP, BREAK) and tx_state_t enums.
  - Default CLKS_PER_BIT localparam and the HALF derivation.
- One sub-module, uart_rx: synchroniser plus receive FSM, exposing data/valid/frame_err.
- Transmitter FSM stays in the top uart module.

Test Plan:
- Reset: hold rst_n=0 with rxd=1 → echo=00, txd=1, rx_valid=0, tx_busy=0; release → all outputs stable for 1000 cycles.
- Byte 0x01:
  - rxd=0 at cycle 17 for 434 cycles, =1 for 434, =0 for 7·434, then =1.
  - Required: echo=01 with one rx_valid pulse at cycle 4142 (±2); echo still 00 at cycle 4130; echo holds 01 until end of sim.
- Echo transmit: after the 0x01 frame, decode txd at 434 cycles/bit → start 0, bits 1,0,0,0,0,0,0,0, stop 1; tx_busy high for 10·434 cycles.
- Glitch: rxd low for 100 cycles then high → no rx_valid, echo unchanged, receiver back in IDLE.
- Framing error:
  - Send 0xA5 with stop bit low; required: frame_err pulse, echo unchanged.
  - Hold rxd low 2000 more cycles, then high; send 0x3C; required: echo=3C.
- Back-to-back 0x55 then 0xAA with no idle gap → echo=55 then AA, two rx_valid pulses; AA is dropped by tx (only 0x55 appears on txd).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and timing constants for the 8N1 echo UART.
// Both the receiver and the echo transmitter import this package.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
    localparam int unsigned SYNC_STAGES_DEFAULT  = 2;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Mid-bit offset: the start bit is checked half a bit after its falling edge.
    function automatic int unsigned half_bit(input int unsigned cpb);
        return cpb / 32'd2;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronises rxd, samples each bit at its midpoint and reports
// a correctly framed byte (valid) or a low stop bit (frame_err).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int unsigned HALF  = half_bit(CLKS_PER_BIT);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxs;
    rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;

    // Synchroniser shift chain; presets high so reset does not look like a start bit.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
    end

    // Receive FSM next-state, bit sampling and one-cycle result pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rxs) begin
                    state_d = RX_START;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (rxs) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    shift_d = {rxs, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (rxs) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_BREAK: begin
                if (rxs) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_BREAK;
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Receiver state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{1'b1}};
            state_q <= RX_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule

// File: rtl/uart.sv
// Loopback console front end: receives 8N1 bytes on rxd, presents the last good
// byte on echo and retransmits it on txd when the transmitter is free.
module uart
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] echo,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       txd,
    output logic       tx_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [7:0]       rx_data_s;
    logic             rx_valid_s;
    logic             rx_ferr_s;

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             txd_q, txd_d;
    logic             tx_busy_q, tx_busy_d;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .data      (rx_data_s),
        .valid     (rx_valid_s),
        .frame_err (rx_ferr_s)
    );

    assign echo      = rx_data_s;
    assign rx_valid  = rx_valid_s;
    assign frame_err = rx_ferr_s;
    assign txd       = txd_q;
    assign tx_busy   = tx_busy_q;

    // Transmit FSM; a byte arriving while not idle (including the final stop cycle) is dropped.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_busy_d  = tx_busy_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (rx_valid_s) begin
                    tx_shift_d = rx_data_s;
                    tx_cnt_d   = {CNT_W{1'b0}};
                    txd_d      = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_state_d = TX_START;
                end else begin
                    txd_d      = 1'b1;
                    tx_busy_d  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = {CNT_W{1'b0}};
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = {CNT_W{1'b0}};
                    if (tx_bit_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = {CNT_W{1'b0}};
                    tx_busy_d  = 1'b0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_cnt_d   = {CNT_W{1'b0}};
                txd_d      = 1'b1;
                tx_busy_d  = 1'b0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // Transmitter state and line registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= {CNT_W{1'b0}};
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

endmodule

// File: tb/tb_uart.sv
// Directed bench for the echo UART: frames are driven on rxd, expected bytes go to
// scoreboards and are popped when rx_valid fires or when a txd frame is decoded.
module tb_uart;

    localparam int unsigned CPB = 434;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       rxd   = 1'b1;
    logic [7:0] echo;
    logic       rx_valid;
    logic       frame_err;
    logic       txd;
    logic       tx_busy;

    uart #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .echo      (echo),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .txd       (txd),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        int unsigned t0;
    } rx_exp_t;

    rx_exp_t     rx_q[$];
    logic [7:0]  tx_q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_valid = 0;
    int          n_ferr = 0;
    int          n_tx = 0;
    int unsigned busy_len = 0;
    logic [7:0]  echo_prev = 8'h00;
    rx_exp_t     mon_e;
    int unsigned mon_lat;
    logic [7:0]  dec_byte;
    logic        dec_start;
    logic        dec_stop;
    int          bad;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge so frames can be chained with no gap.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                             input logic exp_rx, input logic exp_tx);
        rx_exp_t e;
        e.data = b;
        e.t0   = cyc;
        if (exp_rx) rx_q.push_back(e);
        if (exp_tx) tx_q.push_back(b);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_tx_idle();
        int k = 0;
        while (tx_busy && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check("tx_idle_timeout", tx_busy, 1'b0);
    endtask

    // Receive-side scoreboard plus echo-stability and pulse counting.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                n_valid++;
                if (rx_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $error("FAIL rx_unexpected: observed echo %0h expected no rx_valid", echo);
                end else begin
                    mon_e   = rx_q.pop_front();
                    mon_lat = cyc - mon_e.t0;
                    check("rx_data", echo, mon_e.data);
                    check("rx_latency_window", (mon_lat >= 4124 && mon_lat <= 4128), 1'b1);
                end
            end
            if (frame_err) n_ferr++;
            if (echo !== echo_prev) check("echo_only_on_valid", rx_valid, 1'b1);
            echo_prev = echo;
            if (tx_busy) begin
                busy_len++;
            end else if (busy_len != 0) begin
                check("tx_busy_len", busy_len, 10 * CPB);
                busy_len = 0;
            end
        end
    end

    // txd decoder: mid-bit sampling of each echoed frame against the transmit scoreboard.
    initial begin
        forever begin
            @(negedge txd);
            repeat (CPB / 2) @(negedge clk);
            dec_start = txd;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                dec_byte[i] = txd;
            end
            repeat (CPB) @(negedge clk);
            dec_stop = txd;
            n_tx++;
            check("tx_start_bit", dec_start, 1'b0);
            check("tx_stop_bit", dec_stop, 1'b1);
            if (tx_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL tx_unexpected: observed byte %0h expected no frame", dec_byte);
            end else begin
                check("tx_data", dec_byte, tx_q.pop_front());
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_echo", echo, 8'h00);
        check("rst_txd", txd, 1'b1);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_tx_busy", tx_busy, 1'b0);
        rst_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (echo !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 ||
                txd !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("idle_stable", bad, 0);

        // Single byte 0x01 and its echo.
        send_byte(8'h01, 1'b1, 1'b1, 1'b1);
        check("echo_01", echo, 8'h01);
        check("valid_count_01", n_valid, 1);
        check("tx_busy_after_01", tx_busy, 1'b1);
        wait_tx_idle();
        check("tx_frames_01", n_tx, 1);

        // Short glitch must be rejected.
        rxd = 1'b0;
        repeat (100) @(negedge clk);
        rxd = 1'b1;
        repeat (1000) @(negedge clk);
        check("glitch_no_valid", n_valid, 1);
        check("glitch_no_ferr", n_ferr, 0);
        check("glitch_echo", echo, 8'h01);

        // Framing error followed by a long break, then a good byte.
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (2000) @(negedge clk);
        rxd = 1'b1;
        repeat (500) @(negedge clk);
        check("ferr_count", n_ferr, 1);
        check("ferr_echo", echo, 8'h01);
        check("ferr_no_valid", n_valid, 1);
        check("ferr_no_tx", tx_busy, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b1, 1'b1);
        check("echo_3c", echo, 8'h3C);
        wait_tx_idle();

        // Back-to-back frames: second arrives as the echo finishes its stop bit and is dropped.
        repeat (100) @(negedge clk);
        send_byte(8'h55, 1'b1, 1'b1, 1'b1);
        check("echo_55", echo, 8'h55);
        send_byte(8'hAA, 1'b1, 1'b1, 1'b0);
        check("echo_aa", echo, 8'hAA);
        check("valid_count_b2b", n_valid, 4);
        wait_tx_idle();
        repeat (5000) @(negedge clk);
        check("tx_frames_total", n_tx, 3);
        check("tx_idle_end", tx_busy, 1'b0);
        check("rx_queue_drained", rx_q.size(), 0);
        check("tx_queue_drained", tx_q.size(), 0);
        check("echo_holds", echo, 8'hAA);
        check("ferr_total", n_ferr, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
